muxf_rr_reg: RTL and testbench
==============================

MUXF_RR_REG -- requirements
Module: muxf_rr_reg

Interface
REQ-001 Parameter WIDTH, default 1: data bits per channel; legal range 1..64.
REQ-002 Parameter N, default 2: channel count; legal range 2..16. SELW = max(1, ceil(log2 N)) is derived.
REQ-003 Parameter RR, default 0: 0 = select-driven mode; 1 = round-robin mode (S ignored).
REQ-004 C  input  1  clock; all state updates on the rising edge.
REQ-005 CLR  input  1  reset; asynchronous, active-high.
REQ-006 CE  input  1  clock enable; when low, all state holds.
REQ-007 I  input  N*WIDTH  channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 IV  input  N  per-channel valid.
REQ-009 IR  output  N  per-channel ready; combinational; at most one bit high.
REQ-010 S  input  SELW  channel select; used only when RR=0.
REQ-011 O  output  WIDTH  registered output data.
REQ-012 OV  output  1  registered output valid.
REQ-013 OR  input  1  downstream ready.
REQ-014 OSEL  output  SELW  registered index of the channel held in O.

Function
REQ-015 The output stage is a single register slot (O, OV, OSEL).
REQ-016 Load enable: LD = CE & (~OV | OR).
REQ-017 Grant, RR=0: G = S when S < N and IV[S] = 1; otherwise no grant.
REQ-018 Grant, RR=1: G = first k with IV[k] = 1, searching P, P+1, ... N-1, 0, ... P-1 (mod N); no grant if IV = 0.
REQ-019 IR[k] = LD & (a grant exists) & (G == k); all other IR bits are 0.
REQ-020 A transfer on channel k occurs in a cycle with IV[k] & IR[k]; in the next cycle O = I[k] as sampled, OSEL = k, OV = 1. Latency is 1 cycle.
REQ-021 LD with no grant: next OV = 0; O and OSEL hold.
REQ-022 OV & ~OR (stall), or CE = 0: O, OV, OSEL and P hold; IR = 0.
REQ-023 OV & OR & grant: consume and reload in the same cycle, giving full throughput of one word per cycle.
REQ-024 RR pointer P (SELW bits, RR=1 only): on each transfer, P <= (G + 1) mod N, wrapping from N-1 to 0. P holds otherwise.
REQ-025 RR fairness: with all IV high and OR high, grants follow 0,1,...,N-1,0,... with no channel skipped.
REQ-026 An IV change while OV & ~OR has no effect on O. A channel may withdraw IV without penalty.
REQ-027 S changing while stalled has no effect; S is sampled only in cycles where LD = 1.
REQ-028 With RR=0 and N not a power of two, S >= N gives no grant and all IR = 0.
REQ-029 No X propagation: O changes only on a transfer or reset.

Reset
REQ-030 While CLR = 1, independent of C and CE: O = 0, OV = 0, OSEL = 0, P = 0.
REQ-031 IR = 0 while CLR = 1.
REQ-032 A CLR pulse mid-stall discards the held word; no replay after release.
REQ-033 The first transfer can occur on the first rising edge of C after CLR falls.

Verification (N=4, WIDTH=8)
REQ-034 RR=0, S=2, IV=4'b0100, I[2]=8'hA5, OR=1, CE=1 -> IR=4'b0100; next cycle O=8'hA5, OSEL=2, OV=1.
REQ-035 RR=1, IV=4'hF held, OR=1, I[k]=8'h10+k -> O sequence 10,11,12,13,10; OSEL 0,1,2,3,0.
REQ-036 OV=1 holding 8'h33, OR=0 for 3 cycles while IV and S toggle -> IR=0, O=8'h33 and OV=1 throughout; when OR rises, the next word loads in the same cycle.
REQ-037 CE=0 with IV=4'hF, OR=1 -> IR=0 and no state change for 2 cycles; when CE returns, RR resumes from the prior P.
REQ-038 CLR asserted asynchronously between edges while OV=1 -> O=0, OV=0, OSEL=0 immediately; P=0, so the next RR grant goes to channel 0 when IV[0]=1.
REQ-039 RR=1, P=3, IV=4'b0010 -> grant to channel 1 (wrap search); P becomes 2.

Source files
------------

// File: rtl/muxf_rr_reg.sv
// muxf_rr_reg
//   N-channel multiplexer into a single registered output slot with a
//   valid/ready handshake on both sides. The channel is chosen either by S
//   (RR=0) or by a rotating round-robin pointer (RR=1). A word that is
//   accepted on channel k appears on O one cycle later, with OSEL = k and
//   OV = 1. The slot can be consumed and reloaded in the same cycle, so it
//   sustains one word per clock.
//
// Ports
//   C     clock; all state changes on the rising edge
//   CLR   asynchronous active-high reset
//   CE    clock enable; when low, all state holds and IR is 0
//   I     channel data, channel k at bits [k*WIDTH +: WIDTH]
//   IV    per-channel valid
//   IR    per-channel ready (combinational, one-hot or zero)
//   S     channel select (RR=0 only)
//   O     registered output data
//   OV    registered output valid
//   OR    downstream ready
//   OSEL  registered index of the channel whose word is in O
module muxf_rr_reg #(
    parameter int WIDTH = 1,
    parameter int N     = 2,
    parameter int RR    = 0,
    localparam int SELW = (N <= 2) ? 1 : $clog2(N)
) (
    input  logic                 C,
    input  logic                 CLR,
    input  logic                 CE,
    input  logic [N*WIDTH-1:0]   I,
    input  logic [N-1:0]         IV,
    output logic [N-1:0]         IR,
    input  logic [SELW-1:0]      S,
    output logic [WIDTH-1:0]     O,
    output logic                 OV,
    input  logic                 OR,
    output logic [SELW-1:0]      OSEL
);

    logic            ld;
    logic            sel_valid;
    logic            rr_valid;
    logic [SELW-1:0] rr_idx;
    logic            grant_valid;
    logic [SELW-1:0] grant_idx;
    logic [SELW-1:0] p;
    logic [SELW-1:0] p_next;
    logic [N-1:0]    rot;
    logic [WIDTH-1:0] grant_data;
    int              rr_off;
    int              rr_sum;

    // The slot may take a new word when it is empty or being drained now.
    assign ld = CE & (~OV | OR);

    // Select mode: an index beyond the last channel never grants.
    assign sel_valid = (int'(S) < N) ? IV[S] : 1'b0;

    // Round-robin search: rotate IV so the pointer channel lands at bit 0,
    // take the lowest set bit, then rotate the offset back into a channel.
    always_comb begin
        rot      = N'({IV, IV} >> p);
        rr_valid = 1'b0;
        rr_off   = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                rr_valid = 1'b1;
                rr_off   = j;
            end
        end
        rr_sum = int'(p) + rr_off;
        if (rr_sum >= N) begin
            rr_sum = rr_sum - N;
        end
        rr_idx = SELW'(rr_sum);
    end

    assign grant_valid = (RR != 0) ? rr_valid : sel_valid;
    assign grant_idx   = (RR != 0) ? rr_idx   : S;

    // Ready is gated by CLR so nothing is offered while reset is held.
    assign IR = (ld && grant_valid && !CLR) ? (N'(1) << grant_idx) : '0;

    always_comb begin
        grant_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant_idx == SELW'(k)) begin
                grant_data = I[k*WIDTH +: WIDTH];
            end
        end
    end

    assign p_next = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + 1'b1;

    // Output slot and pointer. A load cycle without a grant empties the slot
    // but leaves O/OSEL untouched, so O only ever changes on a transfer.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            O    <= '0;
            OV   <= 1'b0;
            OSEL <= '0;
            p    <= '0;
        end else if (ld) begin
            if (grant_valid) begin
                O    <= grant_data;
                OSEL <= grant_idx;
                OV   <= 1'b1;
                p    <= p_next;
            end else begin
                OV   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_muxf_rr_reg.sv
// tb_muxf_rr_reg
//   Drives three instances (N=4 select mode, N=4 round-robin, N=3 select
//   mode) with directed vectors. Expected words are queued when a transfer
//   is issued; a monitor per queued instance pops and compares every word
//   the DUT hands downstream.
module tb_muxf_rr_reg;

    logic clk;
    logic clr;

    // instance 0: RR=0, N=4
    logic        ce0, or0, ov0;
    logic [31:0] i0;
    logic [3:0]  iv0, ir0;
    logic [1:0]  s0, osel0;
    logic [7:0]  o0;

    // instance 1: RR=1, N=4
    logic        ce1, or1, ov1;
    logic [31:0] i1;
    logic [3:0]  iv1, ir1;
    logic [1:0]  s1, osel1;
    logic [7:0]  o1;

    // instance 2: RR=0, N=3
    logic        ce2, or2, ov2;
    logic [23:0] i2;
    logic [2:0]  iv2, ir2;
    logic [1:0]  s2, osel2;
    logic [7:0]  o2;

    logic [9:0] q0[$];
    logic [9:0] q1[$];

    int compared;
    int mismatched;

    muxf_rr_reg #(.WIDTH(8), .N(4), .RR(0)) dut0 (
        .C(clk), .CLR(clr), .CE(ce0), .I(i0), .IV(iv0), .IR(ir0),
        .S(s0), .O(o0), .OV(ov0), .OR(or0), .OSEL(osel0)
    );

    muxf_rr_reg #(.WIDTH(8), .N(4), .RR(1)) dut1 (
        .C(clk), .CLR(clr), .CE(ce1), .I(i1), .IV(iv1), .IR(ir1),
        .S(s1), .O(o1), .OV(ov1), .OR(or1), .OSEL(osel1)
    );

    muxf_rr_reg #(.WIDTH(8), .N(3), .RR(0)) dut2 (
        .C(clk), .CLR(clr), .CE(ce2), .I(i2), .IV(iv2), .IR(ir2),
        .S(s2), .O(o2), .OV(ov2), .OR(or2), .OSEL(osel2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // Each word is consumed exactly once: in a cycle where the slot is full,
    // downstream is ready and CE lets the slot advance.
    always @(negedge clk) begin
        if (!clr && ce0 && ov0 && or0) begin
            if (q0.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL dut0 unexpected word: got %h/%0d expected none", o0, osel0);
            end else begin
                checkOutput("dut0 word", {22'd0, o0, osel0}, {22'd0, q0.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!clr && ce1 && ov1 && or1) begin
            if (q1.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL dut1 unexpected word: got %h/%0d expected none", o1, osel1);
            end else begin
                checkOutput("dut1 word", {22'd0, o1, osel1}, {22'd0, q1.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        clr = 1'b1;
        ce0 = 1'b1; or0 = 1'b1; iv0 = 4'hF; s0 = 2'd0; i0 = '0;
        ce1 = 1'b1; or1 = 1'b1; iv1 = 4'hF; s1 = 2'd0; i1 = '0;
        ce2 = 1'b1; or2 = 1'b1; iv2 = 3'b111; s2 = 2'd0; i2 = '0;

        // reset state, with valid inputs present
        #3;
        checkOutput("reset o0", {24'd0, o0}, 32'd0);
        checkOutput("reset ov0", {31'd0, ov0}, 32'd0);
        checkOutput("reset osel0", {30'd0, osel0}, 32'd0);
        checkOutput("reset ir0", {28'd0, ir0}, 32'd0);
        checkOutput("reset ov1", {31'd0, ov1}, 32'd0);
        checkOutput("reset ir1", {28'd0, ir1}, 32'd0);
        checkOutput("reset ir2", {29'd0, ir2}, 32'd0);

        applyStimulus();
        clr = 1'b0;

        // select mode: channel 2 transfers on the first edge after reset
        s0 = 2'd2; iv0 = 4'b0100; i0[23:16] = 8'hA5;
        iv1 = 4'h0; iv2 = 3'b000;
        #1;
        checkOutput("sel ir0 ch2", {28'd0, ir0}, 32'h4);
        q0.push_back({8'hA5, 2'd2});
        applyStimulus();
        iv0 = 4'h0;
        #1;
        checkOutput("sel o0", {24'd0, o0}, 32'hA5);
        checkOutput("sel osel0", {30'd0, osel0}, 32'd2);
        checkOutput("sel ov0", {31'd0, ov0}, 32'd1);
        applyStimulus();
        #1;
        checkOutput("no grant ov0", {31'd0, ov0}, 32'd0);
        checkOutput("no grant o0 hold", {24'd0, o0}, 32'hA5);
        checkOutput("no grant osel0 hold", {30'd0, osel0}, 32'd2);

        // select points at an idle channel
        s0 = 2'd1; iv0 = 4'b0100;
        #1;
        checkOutput("sel idle ir0", {28'd0, ir0}, 32'd0);

        // stall: slot holds 33 while IV and S toggle
        i0[15:8] = 8'h33; iv0 = 4'b0010;
        #1;
        checkOutput("stall load ir0", {28'd0, ir0}, 32'h2);
        q0.push_back({8'h33, 2'd1});
        applyStimulus();
        or0 = 1'b0; iv0 = 4'hF; s0 = 2'd3; i0[31:24] = 8'h44;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("stall ir0", {28'd0, ir0}, 32'd0);
            checkOutput("stall o0", {24'd0, o0}, 32'h33);
            checkOutput("stall ov0", {31'd0, ov0}, 32'd1);
            applyStimulus();
            iv0 = ~iv0;
            s0  = s0 ^ 2'd1;
        end
        or0 = 1'b1; s0 = 2'd3; iv0 = 4'b1000;
        #1;
        checkOutput("stall release ir0", {28'd0, ir0}, 32'h8);
        q0.push_back({8'h44, 2'd3});
        applyStimulus();
        iv0 = 4'h0;
        #1;
        checkOutput("reload o0", {24'd0, o0}, 32'h44);
        applyStimulus();
        #1;
        checkOutput("drain ov0", {31'd0, ov0}, 32'd0);

        // N=3: out-of-range select never grants, in-range works
        s2 = 2'd3; iv2 = 3'b111;
        #1;
        checkOutput("n3 s3 ir2", {29'd0, ir2}, 32'd0);
        applyStimulus();
        #1;
        checkOutput("n3 s3 ov2", {31'd0, ov2}, 32'd0);
        s2 = 2'd2; i2[23:16] = 8'hC3;
        #1;
        checkOutput("n3 s2 ir2", {29'd0, ir2}, 32'h4);
        applyStimulus();
        iv2 = 3'b000;
        #1;
        checkOutput("n3 o2", {24'd0, o2}, 32'hC3);
        checkOutput("n3 osel2", {30'd0, osel2}, 32'd2);
        checkOutput("n3 ov2", {31'd0, ov2}, 32'd1);

        // round robin: all channels valid, grants 0,1,2,3,0
        for (int k = 0; k < 4; k++) begin
            i1[k*8 +: 8] = 8'h10 + 8'(k);
        end
        iv1 = 4'hF;
        for (int j = 0; j < 5; j++) begin
            #1;
            checkOutput("rr ir1", {28'd0, ir1}, 32'd1 << (j % 4));
            q1.push_back({8'h10 + 8'(j % 4), 2'(j % 4)});
            applyStimulus();
        end

        // clock enable low: nothing moves, ready stays low
        ce1 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            checkOutput("ce0 ir1", {28'd0, ir1}, 32'd0);
            checkOutput("ce0 o1", {24'd0, o1}, 32'h10);
            checkOutput("ce0 osel1", {30'd0, osel1}, 32'd0);
            checkOutput("ce0 ov1", {31'd0, ov1}, 32'd1);
            applyStimulus();
        end
        ce1 = 1'b1;
        #1;
        checkOutput("ce resume ir1", {28'd0, ir1}, 32'h2);
        q1.push_back({8'h11, 2'd1});
        applyStimulus();
        #1;
        checkOutput("rr ir1 ch2", {28'd0, ir1}, 32'h4);
        q1.push_back({8'h12, 2'd2});
        applyStimulus();

        // pointer at 3, only channel 1 valid: search wraps to 1
        iv1 = 4'b0010; i1[15:8] = 8'h5A;
        #1;
        checkOutput("rr wrap ir1", {28'd0, ir1}, 32'h2);
        q1.push_back({8'h5A, 2'd1});
        applyStimulus();
        iv1 = 4'hF;
        #1;
        checkOutput("rr after wrap ir1", {28'd0, ir1}, 32'h4);
        q1.push_back({8'h12, 2'd2});
        applyStimulus();

        // reset mid-stall drops the held word
        or1 = 1'b0; iv1 = 4'h0;
        #1;
        checkOutput("pre-clr o1", {24'd0, o1}, 32'h12);
        #1;
        clr = 1'b1;
        #1;
        checkOutput("async clr o1", {24'd0, o1}, 32'd0);
        checkOutput("async clr ov1", {31'd0, ov1}, 32'd0);
        checkOutput("async clr osel1", {30'd0, osel1}, 32'd0);
        checkOutput("async clr ir1", {28'd0, ir1}, 32'd0);
        q1.delete();
        applyStimulus();
        clr = 1'b0; or1 = 1'b1; iv1 = 4'hF;
        #1;
        checkOutput("post clr ir1", {28'd0, ir1}, 32'h1);
        q1.push_back({8'h10, 2'd0});
        applyStimulus();
        iv1 = 4'h0;
        #1;
        checkOutput("post clr o1", {24'd0, o1}, 32'h10);
        applyStimulus();
        applyStimulus();

        checkOutput("dut0 queue drained", q0.size(), 32'd0);
        checkOutput("dut1 queue drained", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
